// File: rtl/acc_res_drain.sv
// Accumulator result drain: two-entry vector buffer, per-lane requantization
// (rounding shift, optional ReLU, signed saturation), one lane per output beat.
module acc_res_drain #(
  parameter int LANES  = 10,
  parameter int IN_W   = 32,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 8,
  parameter int LANE_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pre_valid,
  output logic                     o_pre_ready,
  input  logic signed [IN_W-1:0]   i_res [LANES],
  input  logic                     i_relu_en,
  output logic                     o_post_valid,
  input  logic                     i_post_ready,
  output logic signed [OUT_W-1:0]  o_data,
  output logic [LANE_W-1:0]        o_lane,
  output logic                     o_last
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam int MAXI = 2**(OUT_W-1) - 1;
  localparam int MINI = -(2**(OUT_W-1));
  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(MAXI);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(MINI);

  logic signed [IN_W-1:0] buf_q [2][LANES];
  logic [1:0]             relu_q;
  logic [1:0]             cnt_q, cnt_d;
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic                   live_q;

  logic pre_fire, post_fire, pop;

  // live_q keeps ready low for the first cycle after reset release
  assign o_pre_ready  = live_q & (cnt_q != 2'd2);
  assign o_post_valid = (cnt_q != 2'd0);
  assign pre_fire     = i_pre_valid & o_pre_ready;
  assign post_fire    = o_post_valid & i_post_ready;
  assign pop          = post_fire & (lane_q == LAST_LANE);

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lane_d = lane_q;
    if (pre_fire) wptr_d = ~wptr_q;
    if (post_fire) lane_d = pop ? '0 : lane_q + LANE_W'(1);
    if (pop) rptr_d = ~rptr_q;
    case ({pre_fire, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      lane_q <= '0;
      live_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lane_q <= lane_d;
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      relu_q <= '0;
      for (int e = 0; e < 2; e++)
        for (int l = 0; l < LANES; l++)
          buf_q[e][l] <= '0;
    end else if (pre_fire) begin
      buf_q[wptr_q]  <= i_res;
      relu_q[wptr_q] <= i_relu_en;
    end
  end

  // Requantize the head lane; one extra bit keeps the rounding add exact
  logic signed [IN_W-1:0] x;
  logic signed [IN_W:0]   ext, rnd, rel, sat;

  assign x   = buf_q[rptr_q][lane_q];
  assign ext = {x[IN_W-1], x};

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (SHIFT - 1);
    assign rnd = (ext + HALF) >>> SHIFT;
  end else begin : g_nornd
    assign rnd = ext;
  end

  always_comb begin
    rel = rnd;
    if (relu_q[rptr_q] && rnd < 0) rel = '0;
    sat = rel;
    if (rel > MAXV) sat = MAXV;
    else if (rel < MINV) sat = MINV;
  end

  assign o_data = o_post_valid ? sat[OUT_W-1:0] : '0;
  assign o_lane = o_post_valid ? lane_q : '0;
  assign o_last = o_post_valid & (lane_q == LAST_LANE);

endmodule

// File: doc/acc_res_drain.md
Name: acc_res_drain

Overview:
- Output-side consumer of the 10-lane 32-bit accumulator result handshake.
- Accepts one full result vector per valid/ready transfer and buffers up to two vectors.
- Requantizes each lane: rounding shift, optional ReLU, signed saturation.
- Emits the lanes one per beat, with lane index and last flag, toward the output feature-map writer.

Parameters:
- LANES, 10, number of lanes per result vector
- IN_W, 32, lane width of the incoming accumulator result (signed)
- OUT_W, 8, output sample width (signed, saturated)
- SHIFT, 8, right-shift amount applied before saturation; legal range 0..IN_W-1
- LANE_W, 4, width of lane index; must satisfy 2^LANE_W >= LANES

Ports:
- i_clk, input, 1, clock
- i_rst_n, input, 1, asynchronous active-low reset
- i_pre_valid, input, 1, result vector valid from the accumulator
- o_pre_ready, output, 1, drain can accept a vector this cycle
- i_res, input, IN_W x [LANES], result vector (unpacked array, lane 0 first)
- i_relu_en, input, 1, ReLU enable, captured together with the vector
- o_post_valid, output, 1, output sample valid
- i_post_ready, input, 1, downstream accepts sample
- o_data, output, OUT_W, requantized sample (signed)
- o_lane, output, LANE_W, lane index of o_data
- o_last, output, 1, high on lane LANES-1

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rst_n. While i_rst_n = 0, all state is cleared.
  - Buffer count = 0; write and read pointers = 0; lane counter = 0.
  - o_post_valid = 0, o_pre_ready = 0.
  - o_data, o_lane and o_last read 0.
  - On the first clock edge after i_rst_n rises, o_pre_ready = 1.
  - Reset asserted mid-vector discards all buffered data with no partial output.
- Handshakes:
  - pre_fire = i_pre_valid & o_pre_ready.
  - post_fire = o_post_valid & i_post_ready.
- Storage:
  - 2-entry ping-pong buffer; each entry holds LANES x IN_W bits plus its relu_en bit.
  - o_pre_ready = (count != 2). It is registered-state only and has no combinational path from i_post_ready.
  - When full, a vector is not accepted in the same cycle the last lane pops.
- Write: on pre_fire, store i_res and i_relu_en at the write pointer, then toggle the write pointer.
- Read:
  - o_post_valid = (count != 0).
  - The head entry is selected by the read pointer and the lane by the lane counter.
- Latency:
  - A vector accepted at edge N into an empty buffer gives o_post_valid = 1 after edge N, with lane 0 presented.
  - Sustained throughput is LANES cycles per vector when i_post_ready is held at 1.
- Lane counter:
  - Increments on post_fire.
  - On post_fire with lane = LANES-1: the counter wraps to 0, the read pointer toggles and the entry is popped.
- Count update:
  - +1 on pre_fire only.
  - -1 on pop only.
  - Unchanged when pre_fire and pop coincide, which is legal when count = 1.
- Output hold: if o_post_valid = 1 and i_post_ready = 0, then o_data, o_lane and o_last hold stable.
- o_last = o_post_valid & (lane == LANES-1).
- Requantization of lane x (signed IN_W), combinational from the buffer:
  - If SHIFT > 0: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits so the add cannot overflow. If SHIFT = 0: r = x.
  - If the entry's relu_en = 1 and r < 0: r = 0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. [-128, 127] by default.
- Protocol rules:
  - i_res and i_relu_en are sampled only on pre_fire.
  - Upstream may drop i_pre_valid without a transfer.
  - The drain never asserts o_pre_ready while count = 2.

Test Plan:
- Single vector:
  - Stimulus: reset, then one vector with lane k = k*256, relu off, SHIFT = 8, i_post_ready = 1.
  - Response: o_post_valid rises the cycle after pre_fire; o_data = 0,1,...,9 over 10 consecutive cycles; o_lane = 0..9; o_last only on lane 9; then o_post_valid = 0.
- Rounding and saturation (SHIFT = 8):
  - Inputs 127, 128, -129, 40000, -40000, 0x7FFFFFFF, relu off.
  - Outputs 0, 1, -1, 127, -128, 127.
- ReLU:
  - Same inputs, relu on.
  - Outputs 0, 1, 0, 127, 0, 127.
  - The following vector, sent with relu off, shows negative values again, proving relu_en is stored per entry.
- Backpressure and full:
  - Hold i_post_ready = 0 and offer 3 vectors.
  - Two are accepted; o_pre_ready = 0 from the cycle after the second accept; lane 0 of vector A holds stable.
  - After release: A lanes 0..9, then B lanes 0..9.
  - o_pre_ready returns to 1 the cycle after A lane 9 fires; the third vector is then accepted.
- Simultaneous push and pop:
  - With count = 1 and i_post_ready = 1, present a new vector on the cycle of lane 9.
  - Count stays 1; the next cycle shows lane 0 of the new vector with no bubble.
- Reset mid-stream:
  - Pull i_rst_n low asynchronously, between clock edges, during lane 4 of a vector with a second vector buffered.
  - o_post_valid and o_pre_ready drop to 0 immediately.
  - After release, no stale lanes appear, and a fresh vector drains starting at lane 0.
